// File: rtl/uart_tx_tick_if.sv
// rtl/uart_tx_tick_if.sv - start/tick/data inputs and serial/status outputs of the UART transmitter
interface uart_tx_tick_if #(
    parameter int DBIT = 8
);
    logic            i_tx_start;
    logic            i_s_tick;
    logic [DBIT-1:0] i_din;
    logic            o_tx;
    logic            o_busy;
    logic            o_tx_done_tick;

    modport master (
        output i_tx_start,
        output i_s_tick,
        output i_din,
        input  o_tx,
        input  o_busy,
        input  o_tx_done_tick
    );

    modport slave (
        input  i_tx_start,
        input  i_s_tick,
        input  i_din,
        output o_tx,
        output o_busy,
        output o_tx_done_tick
    );
endinterface

// File: rtl/uart_tx_tick.sv
// rtl/uart_tx_tick.sv - 8N1 UART transmitter paced by an external oversampling tick
module uart_tx_tick #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OS      = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    uart_tx_tick_if.slave bus
);
    localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    // Next-state logic; the line level is computed here so o_tx comes straight from a flop.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Ticks are ignored here; a start is taken even if a tick arrives with it.
                tx_d = 1'b1;
                if (bus.i_tx_start) begin
                    b_d     = bus.i_din;
                    s_d     = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bus.i_s_tick) begin
                    if (s_q == S_W'(OS - 1)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.i_s_tick) begin
                    if (s_q == S_W'(OS - 1)) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_W'(DBIT - 1)) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + N_W'(1);
                            tx_d = b_d[0];
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: begin
                // STOP: hold the line high for SB_TICK ticks, then pulse done.
                tx_d = 1'b1;
                if (bus.i_s_tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
        endcase
    end

    // State registers; asynchronous reset aborts any frame and forces the line idle at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_tx           = tx_q;
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_tx_done_tick = done_q;
endmodule
